debug_mem_sequencer: RTL
========================

Name: debug_mem_sequencer

Overview:
Cycle-domain execution stage fed by the debug controller's decoded JTAG user operations (one-cycle command strobe plus op/data). It holds the debug address/data registers and drives CPU halt/reset requests. It runs imem/dmem accesses over a req/gnt/rvalid handshake with a timeout. Every accepted command produces one completion record (data, status, toggle) for return to the JTAG domain.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
ADDR_INC, 4, address post-increment after a successful memory op
TIMEOUT_CYCLES, 255, max cycles waiting for mem_gnt or mem_rvalid (>=2)
RESET_CYCLES, 16, width of reset_req pulse (>=1)

Ports:
cpu_clk  in  1  clock
cpu_rstn  in  1  reset
cmd_valid  in  1  one-cycle command strobe
cmd_op  in  8  operation code
cmd_data  in  32  operand (low ADDR_W/DATA_W bits used)
cpu_halted  in  1  CPU halted status
halt_req  out  1  level request to halt CPU
reset_req  out  1  CPU reset request pulse
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read
mem_sel  out  1  0=imem, 1=dmem
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
busy  out  1  command in progress
cmd_overrun  out  1  sticky: command dropped while busy
result_data  out  DATA_W  last read data
result_status  out  2  0 OK, 1 TIMEOUT, 2 NOT_HALTED, 3 ILLEGAL
result_toggle  out  1  flips once per completed command

Behaviour:
- Reset is cpu_rstn, asynchronous, active-low; the clock is cpu_clk. While reset is active, every output is 0, iaddr/idata/daddr/ddata are 0, the FSM is IDLE and all counters are 0.
- Op codes:
  - 00 NOOP: clears cmd_overrun.
  - 01 HALT: sets halt_req=1.
  - 02 RESUME: sets halt_req=0.
  - 03 RESET: pulses reset_req; halt_req is unchanged.
  - 04 RDI, 05 WRI, 06 RDD, 07 WRD: memory accesses.
  - 80/81/82/83 store iaddr/idata/daddr/ddata.
  - 84 STORE_CPUFLAGS: cmd_data[0] is written to halt_req.
  - Any other code: ILLEGAL.
- FSM states: IDLE, REQ, WAIT_R, RST. busy = (state != IDLE).
- Acceptance: a command is accepted only when cmd_valid=1 and the FSM is in IDLE.
  - cmd_valid while busy, including the completion cycle: command dropped, cmd_overrun set to 1, no completion record.
- Completion edge: result_status is written and result_toggle flips on this edge; result_data is updated only by successful reads.
- Immediate ops (NOOP, HALT, RESUME, STORE_*, ILLEGAL): complete on the acceptance edge with status OK (ILLEGAL gives status 3). busy never asserts.
- Memory op with cpu_halted=0: completes on the acceptance edge with status NOT_HALTED and no mem_req.
- Memory op with cpu_halted=1: IDLE->REQ on the acceptance edge.
  - mem_req=1, mem_sel from the op, mem_we=1 for writes.
  - mem_addr and mem_wdata come from the matching addr/data register.
  - All four stay stable while mem_req=1.
- REQ, mem_gnt=1 sampled:
  - Write: ->IDLE, completion with status OK.
  - Read: ->WAIT_R.
  - mem_req drops on the same edge in both cases.
- WAIT_R, mem_rvalid=1 sampled: ->IDLE; result_data=mem_rdata, status OK.
- Successful completion: the address register used post-increments by ADDR_INC, modulo 2^ADDR_W (wrap-around).
- Timeout: a counter clears when entering REQ or WAIT_R.
  - If the state has been held TIMEOUT_CYCLES cycles without gnt/rvalid: ->IDLE, mem_req=0, status TIMEOUT, no increment, result_data unchanged.
  - gnt or rvalid on the same edge as the timeout: the handshake wins.
- RESET op: ->RST; reset_req=1 for exactly RESET_CYCLES cycles, then ->IDLE with completion status OK.
- Minimum latencies:
  - Write: mem_req asserted 1 cycle after acceptance; gnt in that cycle gives completion on edge 2.
  - Read: rvalid in the cycle after gnt gives completion on edge 3.
- mem_rvalid outside WAIT_R and mem_gnt outside REQ are ignored.
- Reset mid-operation: mem_req and reset_req drop immediately; no completion record.

Test Plan:
- Store 80 cmd_data=0x100, 81 0xDEADBEEF, HALT, cpu_halted=1, WRI, gnt after 3 cycles -> mem_req held 3 cycles with addr 0x100 / wdata 0xDEADBEEF / we=1 / sel=0; status 0; iaddr becomes 0x104; result_toggle flips 4 times in total.
- DADDR=0xFFFFFFFC, RDD, gnt immediate, rvalid 2 cycles later with rdata 0x12345678 -> result_data=0x12345678, status 0, daddr wraps to 0x00000000.
- RDI with mem_gnt never asserted, TIMEOUT_CYCLES=255 -> mem_req high exactly 255 cycles; status 1; iaddr unchanged; busy low afterwards.
- cpu_halted=0, WRD -> no mem_req, status 2, completion on the acceptance edge. Op 0x55 -> status 3.
- RESET op, second cmd_valid during the RST state -> reset_req high exactly 16 cycles; cmd_overrun=1; one toggle only; NOOP afterwards clears cmd_overrun.
- cpu_rstn asserted while in WAIT_R -> all outputs 0 asynchronously; after release the next RDD works normally from daddr=0.

Source files
------------

// File: rtl/debug_mem_sequencer_if.sv
// debug_mem_sequencer_if: memory bus (req/we/sel/addr/wdata out, gnt/rvalid/rdata in) between sequencer (master) and imem/dmem (slave)
interface debug_mem_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic req;
  logic we;
  logic sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, sel, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, sel, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer: executes decoded debug ops (cmd_*), holds debug addr/data regs, drives halt_req/reset_req and the mem bus, reports each completion on result_*
module debug_mem_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_INC = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_CYCLES = 16
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic cmd_valid,
  input  logic [7:0] cmd_op,
  input  logic [31:0] cmd_data,
  input  logic cpu_halted,
  output logic halt_req,
  output logic reset_req,
  debug_mem_sequencer_if.master mem,
  output logic busy,
  output logic cmd_overrun,
  output logic [DATA_W-1:0] result_data,
  output logic [1:0] result_status,
  output logic result_toggle
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, RST = 2'd3;
  localparam int CNT_MAX = TIMEOUT_CYCLES > RESET_CYCLES ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] iaddr, daddr, next_addr;
  logic [DATA_W-1:0] idata, ddata;
  logic is_mem, legal, timed_out, rst_done;
  assign is_mem = cmd_op[7:2] == 6'd1;
  assign legal = cmd_op <= 8'h02 || (cmd_op >= 8'h80 && cmd_op <= 8'h84);
  assign busy = state != IDLE;
  assign next_addr = (mem.sel ? daddr : iaddr) + ADDR_W'(ADDR_INC);
  assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign rst_done = cnt == CW'(RESET_CYCLES - 1);
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state <= IDLE;
      cnt <= '0;
      iaddr <= '0;
      daddr <= '0;
      idata <= '0;
      ddata <= '0;
      halt_req <= 1'b0;
      reset_req <= 1'b0;
      mem.req <= 1'b0;
      mem.we <= 1'b0;
      mem.sel <= 1'b0;
      mem.addr <= '0;
      mem.wdata <= '0;
      cmd_overrun <= 1'b0;
      result_data <= '0;
      result_status <= 2'd0;
      result_toggle <= 1'b0;
    end else begin
      if (cmd_valid && busy) cmd_overrun <= 1'b1;
      case (state)
        IDLE: if (cmd_valid) begin
          if (is_mem && cpu_halted) begin
            state <= REQ;
            cnt <= '0;
            mem.req <= 1'b1;
            mem.we <= cmd_op[0];
            mem.sel <= cmd_op[1];
            mem.addr <= cmd_op[1] ? daddr : iaddr;
            mem.wdata <= cmd_op[1] ? ddata : idata;
          end else if (cmd_op == 8'h03) begin
            state <= RST;
            cnt <= '0;
            reset_req <= 1'b1;
          end else begin
            result_toggle <= ~result_toggle;
            result_status <= is_mem ? 2'd2 : legal ? 2'd0 : 2'd3;
            case (cmd_op)
              8'h00: cmd_overrun <= 1'b0;
              8'h01: halt_req <= 1'b1;
              8'h02: halt_req <= 1'b0;
              8'h80: iaddr <= cmd_data[ADDR_W-1:0];
              8'h81: idata <= cmd_data[DATA_W-1:0];
              8'h82: daddr <= cmd_data[ADDR_W-1:0];
              8'h83: ddata <= cmd_data[DATA_W-1:0];
              8'h84: halt_req <= cmd_data[0];
              default: ;
            endcase
          end
        end
        REQ: if (mem.gnt) begin
          mem.req <= 1'b0;
          state <= mem.we ? IDLE : WAIT_R;
          cnt <= '0;
          if (mem.we) begin
            result_toggle <= ~result_toggle;
            result_status <= 2'd0;
            if (mem.sel) daddr <= next_addr;
            else iaddr <= next_addr;
          end
        end else if (timed_out) begin
          mem.req <= 1'b0;
          state <= IDLE;
          result_toggle <= ~result_toggle;
          result_status <= 2'd1;
        end else cnt <= cnt + 1'b1;
        WAIT_R: if (mem.rvalid) begin
          state <= IDLE;
          result_data <= mem.rdata;
          result_toggle <= ~result_toggle;
          result_status <= 2'd0;
          if (mem.sel) daddr <= next_addr;
          else iaddr <= next_addr;
        end else if (timed_out) begin
          state <= IDLE;
          result_toggle <= ~result_toggle;
          result_status <= 2'd1;
        end else cnt <= cnt + 1'b1;
        default: if (rst_done) begin
          reset_req <= 1'b0;
          state <= IDLE;
          result_toggle <= ~result_toggle;
          result_status <= 2'd0;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule
